// File: rtl/eth_pcs_tx_gearbox_pkg.sv
// Shared 10GBASE-R PCS constants: sync headers, block framing and TX gearbox sizing.
// The gearbox logic in the other rtl/ files depends on the relationships between these values.
package eth_pcs_tx_gearbox_pkg;

    localparam int unsigned W_SYNC   = 2;
    localparam int unsigned W_DATA   = 64;
    localparam int unsigned W_BLK    = W_SYNC + W_DATA;
    localparam int unsigned W_GB_OUT = 32;
    localparam int unsigned GB_BUF_W = 96;
    localparam int unsigned FILL_W   = 7;

    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    // Line order: blk[0] is the first bit on the wire, so the sync header sits at the bottom.
    function automatic logic [W_BLK-1:0] make_block(input logic [W_SYNC-1:0] sync_hdr,
                                                    input logic [W_DATA-1:0] data);
        return {data, sync_hdr};
    endfunction

endpackage

// File: rtl/eth_pcs_tx_gb_insert.sv
// Combinational insert of one 66-bit block into the gearbox bit buffer at an even offset 0..30.
// Only offset bits [4:1] steer the shifter, which keeps the barrel shift at 16 positions.
module eth_pcs_tx_gb_insert
    import eth_pcs_tx_gearbox_pkg::*;
#(
    parameter int unsigned BUF_W = GB_BUF_W
) (
    input  logic [BUF_W-1:0]  buf_i,
    input  logic [W_BLK-1:0]  blk_i,
    input  logic [FILL_W-1:0] offset_i,
    output logic [BUF_W-1:0]  buf_o
);

    logic [BUF_W-1:0] blk_ext;
    logic [BUF_W-1:0] blk_shifted;
    logic [4:0]       shamt;
    logic             unused_offset;

    // Insert offsets are always even and below 32.
    assign shamt         = {offset_i[4:1], 1'b0};
    assign unused_offset = ^{offset_i[FILL_W-1:5], offset_i[0]};

    always_comb begin
        blk_ext     = BUF_W'(blk_i);
        blk_shifted = blk_ext << shamt;
        buf_o       = buf_i | blk_shifted;
    end

endmodule

// File: rtl/eth_pcs_tx_gearbox.sv
// 10GBASE-R TX gearbox: 66-bit blocks in, continuous 32-bit words out (16 blocks per 33 words).
// fill_q counts valid buffer bits; every bit at or above fill_q is kept zero so inserts can OR.
module eth_pcs_tx_gearbox
    import eth_pcs_tx_gearbox_pkg::*;
#(
    parameter int unsigned W_OUT = W_GB_OUT,
    parameter int unsigned BUF_W = GB_BUF_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [W_SYNC-1:0] i_sync_hdr,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [W_OUT-1:0]  o_data,
    output logic              o_underflow
);

    logic [FILL_W-1:0] fill_q, fill_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic              valid_q, valid_d;
    logic [W_OUT-1:0]  data_q, data_d;
    logic              underflow_q, underflow_d;

    logic              can_load;
    logic [W_BLK-1:0]  blk;
    logic [BUF_W-1:0]  merged;

    assign blk      = make_block(i_sync_hdr, i_data);
    assign can_load = (fill_q < FILL_W'(W_OUT));
    assign o_ready  = !i_reset && can_load;

    eth_pcs_tx_gb_insert #(
        .BUF_W (BUF_W)
    ) u_insert (
        .buf_i    (buf_q),
        .blk_i    (blk),
        .offset_i (fill_q),
        .buf_o    (merged)
    );

    always_comb begin
        fill_d      = fill_q;
        buf_d       = buf_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        underflow_d = 1'b0;

        if (!can_load) begin
            // Enough residual bits for a word: drain only, upstream block is left waiting.
            data_d  = buf_q[W_OUT-1:0];
            buf_d   = buf_q >> W_OUT;
            fill_d  = fill_q - FILL_W'(W_OUT);
            valid_d = 1'b1;
        end else if (i_valid) begin
            data_d  = merged[W_OUT-1:0];
            buf_d   = merged >> W_OUT;
            fill_d  = fill_q + FILL_W'(W_BLK - W_OUT);
            valid_d = 1'b1;
        end else begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fill_q      <= '0;
            buf_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            buf_q       <= buf_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_eth_pcs_tx_gearbox.sv
// Directed and randomised-gap bench for the TX gearbox; a bit-queue model supplies expected words.
module tb_eth_pcs_tx_gearbox;

    logic        i_clk;
    logic        i_reset;
    logic        i_valid;
    logic [1:0]  i_sync_hdr;
    logic [63:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_underflow;

    eth_pcs_tx_gearbox dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_sync_hdr  (i_sync_hdr),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_underflow (o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state: expected line bits in transmit order
    bit          exp_q[$];
    int          m_fill = 0;
    logic        exp_ready, exp_valid, exp_unf, accepted;
    logic [31:0] exp_word = '0;
    logic        act_ready, act_valid, act_unf;
    logic [31:0] act_data;
    logic [6:0]  act_fill;

    task automatic pop_word();
        for (int i = 0; i < 32; i++) begin
            if (exp_q.size() > 0) exp_word[i] = exp_q.pop_front();
            else                  exp_word[i] = 1'b0;
        end
    endtask

    // Drives one clock cycle, advances the model and captures DUT outputs; compares nothing.
    task automatic drive_cycle(input logic v, input logic [1:0] s, input logic [63:0] d);
        logic [65:0] blk;
        blk        = {d, s};
        i_valid    = v;
        i_sync_hdr = s;
        i_data     = d;
        #1;
        act_ready = o_ready;
        exp_ready = !i_reset && (m_fill < 32);
        accepted  = exp_ready && v;
        @(posedge i_clk);
        #1;
        if (i_reset) begin
            m_fill = 0;
            exp_q.delete();
            exp_valid = 1'b0;
            exp_unf   = 1'b0;
            exp_word  = '0;
        end else if (accepted) begin
            for (int i = 0; i < 66; i++) exp_q.push_back(blk[i]);
            pop_word();
            m_fill    = m_fill + 34;
            exp_valid = 1'b1;
            exp_unf   = 1'b0;
        end else if (!exp_ready) begin
            pop_word();
            m_fill    = m_fill - 32;
            exp_valid = 1'b1;
            exp_unf   = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_unf   = 1'b1;
        end
        act_valid = o_valid;
        act_unf   = o_underflow;
        act_data  = o_data;
        act_fill  = dut.fill_q;
    endtask

    task automatic apply_reset();
        i_reset = 1'b1;
        drive_cycle(1'b0, 2'b00, 64'h0);
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        drive_cycle(1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_cycle(1'b1, 2'b10, 64'hAAAA_5555_AAAA_5555);
        n_checks++;
        if (act_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", act_ready);
        else n_pass++;
        n_checks++;
        if (act_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", act_valid);
        else n_pass++;
        n_checks++;
        if (act_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", act_data);
        else n_pass++;
        n_checks++;
        if (act_unf !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", act_unf);
        else n_pass++;
        n_checks++;
        if (act_fill !== 7'd0) $display("FAIL reset_fill: got %0d expected 0", act_fill);
        else n_pass++;
        i_reset = 1'b0;
        i_valid = 1'b0;
        #1;
        n_checks++;
        if (o_ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", o_ready);
        else n_pass++;
    endtask

    task automatic test_single_block();
        apply_reset();
        drive_cycle(1'b1, 2'b01, 64'h0123_4567_89AB_CDEF);
        n_checks++;
        if (act_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", act_ready);
        else n_pass++;
        n_checks++;
        if (act_valid !== 1'b1 || act_data !== 32'h26AF_37BD)
            $display("FAIL single_word0: got v=%b %h expected v=1 26af37bd", act_valid, act_data);
        else n_pass++;
        // This block is presented while not ready and must be ignored
        drive_cycle(1'b1, 2'b11, 64'hDEAD_BEEF_DEAD_BEEF);
        n_checks++;
        if (act_ready !== 1'b0) $display("FAIL single_hold_ready: got %b expected 0", act_ready);
        else n_pass++;
        n_checks++;
        if (act_data !== 32'h048D_159E) $display("FAIL single_word1: got %h expected 048d159e", act_data);
        else n_pass++;
        n_checks++;
        if (act_fill !== 7'd2) $display("FAIL single_fill: got %0d expected 2", act_fill);
        else n_pass++;
        drive_cycle(1'b0, 2'b00, 64'h0);
        n_checks++;
        if (act_unf !== 1'b1 || act_valid !== 1'b0 || act_data !== 32'h048D_159E)
            $display("FAIL single_underflow: got u=%b v=%b %h expected u=1 v=0 048d159e",
                     act_unf, act_valid, act_data);
        else n_pass++;
        drive_cycle(1'b1, 2'b10, 64'h0);
        n_checks++;
        if (act_data !== 32'h0000_0008) $display("FAIL single_tail: got %h expected 00000008", act_data);
        else n_pass++;
    endtask

    task automatic test_continuous();
        int n_ready = 0;
        int n_words = 0;
        int k = 0;
        logic want_ready;
        apply_reset();
        for (int t = 0; t < 33; t++) begin
            drive_cycle(1'b1, k[0] ? 2'b10 : 2'b01, {32'hC0DE_0000 | 32'(k), 32'h1357_9BDF ^ 32'(k * 7)});
            if (act_ready) n_ready++;
            if (act_ready) k++;
            if (act_valid) n_words++;
            want_ready = (t % 2 == 0) && (t < 32);
            n_checks++;
            if (act_ready !== want_ready)
                $display("FAIL cont_ready t=%0d: got %b expected %b", t, act_ready, want_ready);
            else n_pass++;
            n_checks++;
            if (act_valid !== 1'b1 || act_data !== exp_word)
                $display("FAIL cont_word t=%0d: got v=%b %h expected v=1 %h", t, act_valid, act_data, exp_word);
            else n_pass++;
        end
        n_checks++;
        if (act_fill !== 7'd0) $display("FAIL cont_fill_end: got %0d expected 0", act_fill);
        else n_pass++;
        n_checks++;
        if (n_ready != 16) $display("FAIL cont_blocks: got %0d expected 16", n_ready);
        else n_pass++;
        n_checks++;
        if (n_words != 33) $display("FAIL cont_words: got %0d expected 33", n_words);
        else n_pass++;
    endtask

    task automatic test_underflow();
        logic [31:0] held;
        apply_reset();
        drive_cycle(1'b1, 2'b01, 64'hFEDC_BA98_7654_3210);
        drive_cycle(1'b1, 2'b10, 64'h1111_2222_3333_4444);
        held = act_data;
        drive_cycle(1'b0, 2'b01, 64'h0);
        n_checks++;
        if (act_unf !== 1'b1 || act_valid !== 1'b0)
            $display("FAIL uf_pulse: got u=%b v=%b expected u=1 v=0", act_unf, act_valid);
        else n_pass++;
        n_checks++;
        if (act_fill !== 7'd2 || act_data !== held)
            $display("FAIL uf_hold: got fill=%0d %h expected fill=2 %h", act_fill, act_data, held);
        else n_pass++;
        for (int t = 0; t < 10; t++) begin
            drive_cycle(1'b1, t[0] ? 2'b01 : 2'b10, {32'hA5A5_0000 | 32'(t), 32'h0F0F_F0F0 + 32'(t)});
            n_checks++;
            if (act_unf !== 1'b0 || act_valid !== 1'b1 || act_data !== exp_word)
                $display("FAIL uf_resume t=%0d: got u=%b v=%b %h expected u=0 v=1 %h",
                         t, act_unf, act_valid, act_data, exp_word);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive_cycle(1'b1, 2'b01, 64'h0123_0000_FFFF_0001);
        i_valid = 1'b0;
        i_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        n_checks++;
        if (o_ready !== 1'b0) $display("FAIL bp_ready_lo: got %b expected 0", o_ready);
        else n_pass++;
        drive_cycle(1'b1, 2'b11, 64'hBAD1_BAD1_BAD1_BAD1);
        n_checks++;
        if (act_ready !== 1'b0) $display("FAIL bp_ready_v: got %b expected 0", act_ready);
        else n_pass++;
        i_valid = 1'b0;
        #1;
        n_checks++;
        if (o_ready !== 1'b1) $display("FAIL bp_ready_hi: got %b expected 1", o_ready);
        else n_pass++;
        drive_cycle(1'b1, 2'b01, 64'h5555_6666_7777_8888);
        n_checks++;
        if (act_data !== exp_word) $display("FAIL bp_word_b0: got %h expected %h", act_data, exp_word);
        else n_pass++;
        drive_cycle(1'b1, 2'b10, 64'hBAD2_BAD2_BAD2_BAD2);
        n_checks++;
        if (act_data !== exp_word) $display("FAIL bp_word_b1: got %h expected %h", act_data, exp_word);
        else n_pass++;
        drive_cycle(1'b1, 2'b10, 64'h0);
        n_checks++;
        if (act_data !== exp_word) $display("FAIL bp_word_b2: got %h expected %h", act_data, exp_word);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive_cycle(1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_cycle(1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_cycle(1'b1, 2'b10, 64'hEEEE_EEEE_EEEE_EEEE);
        n_checks++;
        if (act_fill !== 7'd36) $display("FAIL mid_fill_pre: got %0d expected 36", act_fill);
        else n_pass++;
        i_reset = 1'b1;
        drive_cycle(1'b1, 2'b01, 64'h7777_7777_7777_7777);
        n_checks++;
        if (act_ready !== 1'b0) $display("FAIL mid_ready: got %b expected 0", act_ready);
        else n_pass++;
        n_checks++;
        if (act_valid !== 1'b0 || act_fill !== 7'd0 || act_data !== 32'h0)
            $display("FAIL mid_state: got v=%b fill=%0d %h expected v=0 fill=0 00000000",
                     act_valid, act_fill, act_data);
        else n_pass++;
        i_reset = 1'b0;
        drive_cycle(1'b1, 2'b10, 64'h0000_0000_1234_5678);
        n_checks++;
        if (act_valid !== 1'b1 || act_data !== 32'h48D1_59E2)
            $display("FAIL mid_first: got v=%b %h expected v=1 48d159e2", act_valid, act_data);
        else n_pass++;
    endtask

    task automatic test_random_gaps();
        int n_blk = 0;
        int cyc = 0;
        int exp_unf_cnt = 0;
        int act_unf_cnt = 0;
        logic v;
        apply_reset();
        while (n_blk < 10000 && cyc < 60000) begin
            v = ($urandom_range(0, 3) != 0);
            drive_cycle(v, 2'($urandom), {$urandom, $urandom});
            cyc++;
            if (accepted) n_blk++;
            if (exp_unf) exp_unf_cnt++;
            if (act_unf) act_unf_cnt++;
            n_checks++;
            if (act_ready !== exp_ready || act_fill !== 7'(m_fill))
                $display("FAIL rnd_ctrl c=%0d: got r=%b fill=%0d expected r=%b fill=%0d",
                         cyc, act_ready, act_fill, exp_ready, m_fill);
            else n_pass++;
            n_checks++;
            if (act_valid !== exp_valid || act_unf !== exp_unf || act_data !== exp_word)
                $display("FAIL rnd_out c=%0d: got v=%b u=%b %h expected v=%b u=%b %h",
                         cyc, act_valid, act_unf, act_data, exp_valid, exp_unf, exp_word);
            else n_pass++;
        end
        n_checks++;
        if (n_blk != 10000) $display("FAIL rnd_budget: got %0d expected 10000", n_blk);
        else n_pass++;
        n_checks++;
        if (act_unf_cnt != exp_unf_cnt)
            $display("FAIL rnd_uf_count: got %0d expected %0d", act_unf_cnt, exp_unf_cnt);
        else n_pass++;
    endtask

    initial begin
        i_reset    = 1'b1;
        i_valid    = 1'b0;
        i_sync_hdr = 2'b00;
        i_data     = 64'h0;
        test_reset();
        test_single_block();
        test_continuous();
        test_underflow();
        test_backpressure();
        test_reset_mid();
        test_random_gaps();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
